// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite slave types: response codes, channel FSM states, strobe width.
package axi4_lite_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_DATA,
    WR_WAIT_ADDR,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  function automatic resp_t resp_for(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite slave bus bundle; master drives requests, slave drives readies and responses.
interface axi4_lite_slave_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]    S_AWADDR;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [DATA_WIDTH-1:0] S_WDATA;
  logic [3:0]            S_WSTRB;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic [1:0]            S_BRESP;
  logic                  S_BVALID;
  logic                  S_BREADY;
  logic [ADDRESS-1:0]    S_ARADDR;
  logic                  S_ARVALID;
  logic                  S_ARREADY;
  logic [DATA_WIDTH-1:0] S_RDATA;
  logic [1:0]            S_RRESP;
  logic                  S_RVALID;
  logic                  S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
           S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
           S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// Register array with byte-lane write merge, one write port and one combinational read port.
// Latency: write commits on the clock edge with wr_en; read is combinational.
// Backpressure: none, always accepts.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = regs[rd_idx];

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register slave; AXI4_LITE_SLAVE_WSTRB_EN enables per-byte write strobes.
// Latency: BVALID one cycle after the completing AW/W handshake, RVALID one cycle after AR.
// Backpressure: holds B/R until BREADY/RREADY; no new AW/W or AR accepted while a response is pending.
module axi4_lite_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axi4_lite_slave_if.slave  s
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int WA_W  = ADDRESS - 2;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [WA_W-1:0]       aw_waddr_q, wr_waddr, rd_waddr;
  logic [DATA_WIDTH-1:0] wdata_q, wr_dat, rdata_q, rf_rd_dat;
  logic [STRB_W-1:0]     wr_strb;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
  logic [STRB_W-1:0]     wstrb_q;
`endif
  logic                  awready, wready, arready, rvalid, wr_fire;
  logic                  wr_in_range, rd_in_range;
  resp_t                 bresp_q, rresp_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Commit source muxes: a channel handshaking this cycle supplies its live value, else the latched one.
  always_comb begin
    wr_next  = wr_state;
    awready  = 1'b0;
    wready   = 1'b0;
    wr_fire  = 1'b0;
    wr_waddr = aw_waddr_q;
    wr_dat   = wdata_q;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    wr_strb  = wstrb_q;
`else
    wr_strb  = '1;
`endif
    case (wr_state)
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (s.S_AWVALID && s.S_WVALID) begin
          wr_fire  = 1'b1;
          wr_waddr = s.S_AWADDR[ADDRESS-1:2];
          wr_dat   = s.S_WDATA;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
          wr_strb  = s.S_WSTRB;
`endif
          wr_next  = WR_RESP;
        end else if (s.S_AWVALID) begin
          wr_next = WR_WAIT_DATA;
        end else if (s.S_WVALID) begin
          wr_next = WR_WAIT_ADDR;
        end
      end
      WR_WAIT_DATA: begin
        wready = 1'b1;
        if (s.S_WVALID) begin
          wr_fire = 1'b1;
          wr_dat  = s.S_WDATA;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
          wr_strb = s.S_WSTRB;
`endif
          wr_next = WR_RESP;
        end
      end
      WR_WAIT_ADDR: begin
        awready = 1'b1;
        if (s.S_AWVALID) begin
          wr_fire  = 1'b1;
          wr_waddr = s.S_AWADDR[ADDRESS-1:2];
          wr_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s.S_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready = 1'b1;
        if (s.S_ARVALID) rd_next = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (s.S_RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign rd_waddr    = s.S_ARADDR[ADDRESS-1:2];
  assign wr_in_range = (wr_waddr >> IDX_W) == '0;
  assign rd_in_range = (rd_waddr >> IDX_W) == '0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_waddr_q <= '0;
      wdata_q    <= '0;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
      wstrb_q    <= '0;
`endif
      bresp_q    <= OKAY;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      if (awready && s.S_AWVALID) aw_waddr_q <= s.S_AWADDR[ADDRESS-1:2];
      if (wready && s.S_WVALID) begin
        wdata_q <= s.S_WDATA;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
        wstrb_q <= s.S_WSTRB;
`endif
      end
      if (wr_fire) bresp_q <= resp_for(wr_in_range);
      if (arready && s.S_ARVALID) begin
        rdata_q <= rd_in_range ? rf_rd_dat : '0;
        rresp_q <= resp_for(rd_in_range);
      end
    end
  end

  axi4_lite_slave_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (wr_fire && wr_in_range),
    .wr_idx  (wr_waddr[IDX_W-1:0]),
    .wr_dat  (wr_dat),
    .wr_strb (wr_strb),
    .rd_idx  (rd_waddr[IDX_W-1:0]),
    .rd_dat  (rf_rd_dat)
  );

  assign s.S_AWREADY = awready;
  assign s.S_WREADY  = wready;
  assign s.S_BVALID  = (wr_state == WR_RESP);
  assign s.S_BRESP   = bresp_q;
  assign s.S_ARREADY = arready;
  assign s.S_RVALID  = rvalid;
  assign s.S_RRESP   = rresp_q;
  assign s.S_RDATA   = rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: write/read ordering, strobes, errors, backpressure, reset.
module tb_axi4_lite_slave;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  axi4_lite_slave_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave #(
    .ADDRESS    (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s       (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_both(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
    bus.S_AWADDR  = addr;
    bus.S_WDATA   = data;
    bus.S_WSTRB   = strb;
    bus.S_AWVALID = 1'b1;
    bus.S_WVALID  = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    chk({tag, "_bvalid"}, 32'(bus.S_BVALID), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.S_BRESP), 32'(exp_resp));
    tick();
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    bus.S_ARADDR  = addr;
    bus.S_ARVALID = 1'b1;
    chk({tag, "_arready"}, 32'(bus.S_ARREADY), 32'd1);
    tick();
    bus.S_ARVALID = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.S_RVALID), 32'd1);
    chk({tag, "_rdata"}, bus.S_RDATA, exp_data);
    chk({tag, "_rresp"}, 32'(bus.S_RRESP), 32'(exp_resp));
    tick();
    chk({tag, "_rvalid_done"}, 32'(bus.S_RVALID), 32'd0);
    chk({tag, "_rdata_idle"}, bus.S_RDATA, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] strb_exp;
    bus.S_AWADDR  = '0;
    bus.S_AWVALID = 1'b0;
    bus.S_WDATA   = '0;
    bus.S_WSTRB   = 4'hF;
    bus.S_WVALID  = 1'b0;
    bus.S_BREADY  = 1'b1;
    bus.S_ARADDR  = '0;
    bus.S_ARVALID = 1'b0;
    bus.S_RREADY  = 1'b1;

    #3;
    chk("rst_bvalid", 32'(bus.S_BVALID), 32'd0);
    chk("rst_rvalid", 32'(bus.S_RVALID), 32'd0);
    chk("rst_rdata", bus.S_RDATA, 32'd0);
    chk("rst_bresp", 32'(bus.S_BRESP), 32'd0);
    chk("rst_rresp", 32'(bus.S_RRESP), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    chk("post_rst_awready", 32'(bus.S_AWREADY), 32'd1);
    chk("post_rst_wready", 32'(bus.S_WREADY), 32'd1);
    chk("post_rst_arready", 32'(bus.S_ARREADY), 32'd1);

    // Simultaneous AW and W
    bus.S_AWADDR  = 32'h04;
    bus.S_WDATA   = 32'hDEADBEEF;
    bus.S_AWVALID = 1'b1;
    bus.S_WVALID  = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    chk("wr04_bvalid", 32'(bus.S_BVALID), 32'd1);
    chk("wr04_bresp", 32'(bus.S_BRESP), 32'd0);
    chk("wr04_awready_resp", 32'(bus.S_AWREADY), 32'd0);
    chk("wr04_wready_resp", 32'(bus.S_WREADY), 32'd0);
    tick();
    chk("wr04_bvalid_done", 32'(bus.S_BVALID), 32'd0);
    chk("wr04_awready_idle", 32'(bus.S_AWREADY), 32'd1);
    do_read("rd04", 32'h04, 32'hDEADBEEF, 2'b00);

    // W three cycles ahead of AW
    bus.S_WDATA  = 32'h12345678;
    bus.S_WVALID = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    chk("wfirst_wready", 32'(bus.S_WREADY), 32'd0);
    chk("wfirst_awready", 32'(bus.S_AWREADY), 32'd1);
    tick();
    tick();
    chk("wfirst_no_bvalid", 32'(bus.S_BVALID), 32'd0);
    bus.S_AWADDR  = 32'h08;
    bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    chk("wfirst_bvalid", 32'(bus.S_BVALID), 32'd1);
    chk("wfirst_bresp", 32'(bus.S_BRESP), 32'd0);
    tick();
    do_read("rd08", 32'h08, 32'h12345678, 2'b00);

    // AW one cycle ahead of W
    bus.S_AWADDR  = 32'h10;
    bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    chk("awfirst_awready", 32'(bus.S_AWREADY), 32'd0);
    chk("awfirst_wready", 32'(bus.S_WREADY), 32'd1);
    bus.S_WDATA  = 32'hA5A5A5A5;
    bus.S_WVALID = 1'b1;
    tick();
    bus.S_WVALID = 1'b0;
    chk("awfirst_bvalid", 32'(bus.S_BVALID), 32'd1);
    tick();
    do_read("rd10", 32'h10, 32'hA5A5A5A5, 2'b00);

    // Partial strobe
    write_both("wr0c_ones", 32'h0C, 32'hFFFFFFFF, 4'hF, 2'b00);
    write_both("wr0c_strb", 32'h0C, 32'h00000000, 4'b0101, 2'b00);
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    strb_exp = 32'hFF00FF00;
`else
    strb_exp = 32'h00000000;
`endif
    do_read("rd0c", 32'h0C, strb_exp, 2'b00);
    bus.S_WSTRB = 4'hF;

    // Read on the same edge as a write commit to the same register sees the old value
    bus.S_AWADDR  = 32'h04;
    bus.S_WDATA   = 32'h11111111;
    bus.S_ARADDR  = 32'h04;
    bus.S_AWVALID = 1'b1;
    bus.S_WVALID  = 1'b1;
    bus.S_ARVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    bus.S_ARVALID = 1'b0;
    chk("raw_rvalid", 32'(bus.S_RVALID), 32'd1);
    chk("raw_rdata_old", bus.S_RDATA, 32'hDEADBEEF);
    chk("raw_bvalid", 32'(bus.S_BVALID), 32'd1);
    tick();
    do_read("rd04_new", 32'h04, 32'h11111111, 2'b00);

    // Address range boundary
    write_both("wr3c", 32'h3C, 32'h0BADF00D, 4'hF, 2'b00);
    do_read("rd3c", 32'h3C, 32'h0BADF00D, 2'b00);
    write_both("wr40", 32'h40, 32'hCAFEF00D, 4'hF, 2'b10);
    do_read("rd40", 32'h40, 32'h0, 2'b10);
    do_read("rd00_untouched", 32'h00, 32'h0, 2'b00);

    // Response backpressure
    bus.S_BREADY = 1'b0;
    bus.S_AWADDR  = 32'h14;
    bus.S_WDATA   = 32'h55AA55AA;
    bus.S_AWVALID = 1'b1;
    bus.S_WVALID  = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bstall%0d_bvalid", i), 32'(bus.S_BVALID), 32'd1);
      chk($sformatf("bstall%0d_bresp", i), 32'(bus.S_BRESP), 32'd0);
      chk($sformatf("bstall%0d_awready", i), 32'(bus.S_AWREADY), 32'd0);
      chk($sformatf("bstall%0d_wready", i), 32'(bus.S_WREADY), 32'd0);
      tick();
    end
    bus.S_BREADY = 1'b1;
    tick();
    chk("bstall_release", 32'(bus.S_BVALID), 32'd0);

    bus.S_RREADY  = 1'b0;
    bus.S_ARADDR  = 32'h14;
    bus.S_ARVALID = 1'b1;
    tick();
    bus.S_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstall%0d_rvalid", i), 32'(bus.S_RVALID), 32'd1);
      chk($sformatf("rstall%0d_rdata", i), bus.S_RDATA, 32'h55AA55AA);
      chk($sformatf("rstall%0d_arready", i), 32'(bus.S_ARREADY), 32'd0);
      tick();
    end
    bus.S_RREADY = 1'b1;
    tick();
    chk("rstall_release", 32'(bus.S_RVALID), 32'd0);

    // Reset in the middle of a write after AW only
    bus.S_AWADDR  = 32'h04;
    bus.S_AWVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0;
    chk("midrst_awready_pre", 32'(bus.S_AWREADY), 32'd0);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("midrst_awready", 32'(bus.S_AWREADY), 32'd1);
    chk("midrst_wready", 32'(bus.S_WREADY), 32'd1);
    chk("midrst_bvalid", 32'(bus.S_BVALID), 32'd0);
    chk("midrst_rdata", bus.S_RDATA, 32'd0);
    #2;
    ARESETN = 1'b1;
    tick();
    chk("midrst_no_bvalid0", 32'(bus.S_BVALID), 32'd0);
    tick();
    chk("midrst_no_bvalid1", 32'(bus.S_BVALID), 32'd0);
    do_read("post_rst_04", 32'h04, 32'h0, 2'b00);
    do_read("post_rst_08", 32'h08, 32'h0, 2'b00);
    do_read("post_rst_3c", 32'h3C, 32'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
